stack_test_ctrl: RTL and testbench
==================================

// Module: stack_test_ctrl
// PURPOSE
//  Bottom-layer sequencer for the 3D-stack self-test chain. Holds the per-layer self-test
//  blocks in reset, releases them, and snoops the inter-layer frames
//  {4'hA, p_state[3:0], src_id[3:0], dst_id[3:0], 16'hBEAF}.
//  Records each layer's final power state, declares completion or timeout, and retries.
//  Sits beside the layer-0 self-test block; results go to the test/status register file.
// PARAMETERS
//  MAX_LAYERS   8     table depth; legal cfg_layers range is 1..MAX_LAYERS (<=16)
//  RST_CYCLES   4     cycles test_rst_n is held low per launch (>=1)
//  TIMEOUT      1024  idle cycles without a valid frame before a launch is declared dead
//  MAX_RETRY    2     extra launches after the first timeout (0 = no retry)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  start        in   1   one-cycle request; sampled only in IDLE
//  cfg_layers   in   4   expected layer count; captured on accepted start
//  bus_valid    in   1   bus_in carries a frame this cycle
//  bus_in       in   32  snooped inter-layer frame
//  rd_addr      in   4   result table read address
//  test_rst_n   out  1   reset to the stack self-test blocks (active low)
//  busy         out  1   high in RESET_STACK / RUN
//  done         out  1   level; high in DONE
//  error        out  1   level; high in FAIL
//  err_code     out  2   0 none, 1 bad cfg, 2 timeout
//  retry_cnt    out  2   launches retried so far (saturates at 3)
//  pmax_warn    out  1   sticky: some recorded p_state == 4'hF
//  rd_pstate    out  4   table[rd_addr]; 0 if rd_addr >= MAX_LAYERS (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0 (test_rst_n=0), table/seen/counters cleared.
//  Valid frame: bus_valid && bus_in[15:0]==16'hBEAF && bus_in[31:28]==4'hA.
//   src=bus_in[23:20], ps=bus_in[27:24].
//  FSM:
//   IDLE: start && cfg_layers in 1..MAX_LAYERS -> RESET_STACK; clear table, seen,
//         pmax_warn, retry_cnt, err_code.
//         start with cfg_layers==0 or >MAX_LAYERS -> FAIL, err_code=1.
//   RESET_STACK: test_rst_n=0 for exactly RST_CYCLES cycles -> RUN; timeout ctr := 0.
//   RUN: test_rst_n=1. Valid frame with src<cfg_layers: table[src]<=ps, seen[src]<=1,
//        timeout ctr<=0; last write wins.
//        ps==4'hF sets pmax_warn. Frames with src>=cfg_layers are ignored (no ctr reload).
//        Invalid frames are ignored.
//        All seen[cfg_layers-1:0] set (including by this cycle's write) -> DONE next cycle.
//        Ctr reaches TIMEOUT-1 with no valid frame: if retry_cnt<MAX_RETRY -> RESET_STACK,
//        retry_cnt+1, seen cleared (table kept); else -> FAIL, err_code=2.
//        Frame and expiry in the same cycle: frame wins, ctr reloads.
//   DONE: test_rst_n=1, done=1; start (valid cfg) relaunches as from IDLE.
//   FAIL: test_rst_n=0, error=1; start relaunches as from IDLE.
//  start while busy: ignored. bus_valid outside RUN: ignored.
//  rst_n mid-run: immediate return to reset values; stack re-held in reset.
//  Latency: start -> busy=1 next cycle; final frame -> done=1 one cycle later.
// CONFIGURATION
//  STACK_CTRL_STATS_EN defined: adds output frame_cnt[15:0]. It counts every valid frame
//   in RUN, including out-of-range src, saturates at 16'hFFFF, and clears on accepted start.
//  Undefined: no frame_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  cfg_layers=3; frames src 0,1,2 with ps 1,2,3 -> done=1 one cycle after src2;
//   rd_pstate[0..2]=1,2,3; err_code=0.
//  cfg_layers=0 start -> next cycle error=1, err_code=1, test_rst_n=0, busy=0.
//  cfg_layers=2, only src0 frame, MAX_RETRY=2 -> three RESET_STACK pulses of 4 cycles,
//   then FAIL, err_code=2, retry_cnt=2.
//  src1 sends ps 3 then 4'hF -> rd_pstate[1]=4'hF, pmax_warn=1.
//  Valid frame on the exact expiry cycle -> stays in RUN, no retry.
//  Assert rst_n low mid-RUN -> all outputs 0; then start -> clean launch.
//  STACK_CTRL_STATS_EN: 5 valid frames incl. 1 with src>=cfg_layers and 1 bad magic
//   -> frame_cnt=4.

Source files
------------

// File: rtl/stack_test_ctrl.sv
// Bottom-layer sequencer for the 3D-stack self-test chain: launches, snoops layer frames, retries on timeout.
// Optional STACK_CTRL_STATS_EN adds a saturating valid-frame counter output (frame_cnt).
module stack_test_ctrl #(
  parameter int MAX_LAYERS = 8,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 1024,
  parameter int MAX_RETRY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cfg_layers,
  input  logic        bus_valid,
  input  logic [31:0] bus_in,
  input  logic [3:0]  rd_addr,
  output logic        test_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [1:0]  retry_cnt,
  output logic        pmax_warn,
  output logic [3:0]  rd_pstate
`ifdef STACK_CTRL_STATS_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RESET_STACK, RUN, DONE, FAIL} state_t;

  state_t                       state, state_nxt;
  logic [RW-1:0]                rst_cnt;
  logic [TW-1:0]                to_cnt;
  logic [3:0]                   layers;
  logic [MAX_LAYERS-1:0]        seen, seen_nxt, need, wr_oh;
  logic [MAX_LAYERS-1:0][3:0]   ptab;

  logic       frame_ok, in_rng, wr, all_seen, expire, can_start, cfg_ok, launch, retry_ok;
  logic [3:0] src, ps;

  assign src       = bus_in[23:20];
  assign ps        = bus_in[27:24];
  assign frame_ok  = bus_valid && bus_in[15:0] == 16'hBEAF && bus_in[31:28] == 4'hA;
  assign in_rng    = {1'b0, src} < {1'b0, layers};
  assign wr        = state == RUN && frame_ok && in_rng;
  assign expire    = state == RUN && !wr && to_cnt == TW'(TIMEOUT - 1);
  assign can_start = state == IDLE || state == DONE || state == FAIL;
  assign cfg_ok    = cfg_layers != 4'd0 && {1'b0, cfg_layers} <= 5'(MAX_LAYERS);
  assign launch    = start && can_start && cfg_ok;
  assign retry_ok  = 32'(retry_cnt) < MAX_RETRY;

  always_comb begin
    wr_oh = '0;
    need  = '0;
    for (int i = 0; i < MAX_LAYERS; i++) begin
      wr_oh[i] = wr && src == 4'(i);
      need[i]  = 5'(i) < {1'b0, layers};
    end
  end

  // completion counts this cycle's write so done follows the last frame by one cycle
  assign seen_nxt = seen | wr_oh;
  assign all_seen = &(seen_nxt | ~need);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, FAIL: if (start) state_nxt = cfg_ok ? RESET_STACK : FAIL;
      RESET_STACK:      if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = RUN;
      RUN: begin
        if (wr && all_seen) state_nxt = DONE;
        else if (expire)    state_nxt = retry_ok ? RESET_STACK : FAIL;
      end
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      layers    <= '0;
      seen      <= '0;
      ptab      <= '0;
      err_code  <= 2'd0;
      retry_cnt <= 2'd0;
      pmax_warn <= 1'b0;
    end else begin
      state   <= state_nxt;
      rst_cnt <= (state == RESET_STACK) ? rst_cnt + 1'b1 : '0;
      if (state != RUN || wr) to_cnt <= '0;
      else if (!expire)       to_cnt <= to_cnt + 1'b1;
      if (launch) begin
        layers    <= cfg_layers;
        seen      <= '0;
        ptab      <= '0;
        pmax_warn <= 1'b0;
        retry_cnt <= 2'd0;
        err_code  <= 2'd0;
      end else if (start && can_start) begin
        err_code <= 2'd1;
      end else if (wr) begin
        seen <= seen_nxt;
        for (int i = 0; i < MAX_LAYERS; i++)
          if (wr_oh[i]) ptab[i] <= ps;
        if (ps == 4'hF) pmax_warn <= 1'b1;
      end else if (expire) begin
        // table survives a retry so partial results stay readable after a final FAIL
        if (retry_ok) begin
          seen <= '0;
          if (retry_cnt != 2'd3) retry_cnt <= retry_cnt + 1'b1;
        end else begin
          err_code <= 2'd2;
        end
      end
    end
  end

`ifdef STACK_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              frame_cnt <= '0;
    else if (launch)                                         frame_cnt <= '0;
    else if (state == RUN && frame_ok && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
  end
`endif

  assign test_rst_n = state == RUN || state == DONE;
  assign busy       = state == RESET_STACK || state == RUN;
  assign done       = state == DONE;
  assign error      = state == FAIL;

  always_comb begin
    rd_pstate = 4'd0;
    for (int i = 0; i < MAX_LAYERS; i++)
      if (rd_addr == 4'(i)) rd_pstate = ptab[i];
  end

endmodule

// File: tb/tb_stack_test_ctrl.sv
// Directed bench for stack_test_ctrl: done/error events checked by a scoreboard monitor,
// timing and table reads checked inline.
module tb_stack_test_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_layers = '0;
  logic        bus_valid = 1'b0;
  logic [31:0] bus_in = '0;
  logic [3:0]  rd_addr = '0;
  logic        test_rst_n, busy, done, error, pmax_warn;
  logic [1:0]  err_code, retry_cnt;
  logic [3:0]  rd_pstate;
`ifdef STACK_CTRL_STATS_EN
  logic [15:0] frame_cnt;
`endif

  stack_test_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_layers(cfg_layers),
    .bus_valid(bus_valid), .bus_in(bus_in), .rd_addr(rd_addr),
    .test_rst_n(test_rst_n), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .retry_cnt(retry_cnt), .pmax_warn(pmax_warn),
    .rd_pstate(rd_pstate)
`ifdef STACK_CTRL_STATS_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dn;
    logic       er;
    logic [1:0] ec;
    logic [1:0] rc;
    logic       pw;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic push_ev(input logic dn, input logic er, input logic [1:0] ec,
                         input logic [1:0] rc, input logic pw);
    ev_t e;
    e.dn = dn; e.er = er; e.ec = ec; e.rc = rc; e.pw = pw;
    exp_q.push_back(e);
  endtask

  // monitor: every rising done/error is a completion event to be matched in order
  logic done_q = 1'b0, error_q = 1'b0;
  always @(negedge clk) begin
    if ((done && !done_q) || (error && !error_q)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {done, error}, 2'b00);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_done",      32'(done),      32'(e.dn));
        chk("ev_error",     32'(error),     32'(e.er));
        chk("ev_err_code",  32'(err_code),  32'(e.ec));
        chk("ev_retry_cnt", 32'(retry_cnt), 32'(e.rc));
        chk("ev_pmax_warn", 32'(pmax_warn), 32'(e.pw));
      end
    end
    done_q  <= done;
    error_q <= error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] cfg);
    start = 1'b1; cfg_layers = cfg;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] src, input logic [3:0] ps, input logic [15:0] magic = 16'hBEAF);
    bus_valid = 1'b1;
    bus_in = {4'hA, ps, src, 4'h0, magic};
    tick();
    bus_valid = 1'b0;
    bus_in = '0;
  endtask

  // cycles until test_rst_n reaches lvl, bounded
  task automatic cycles_until(input logic lvl, input int limit, output int n);
    n = 0;
    while (test_rst_n !== lvl && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] exp, input string nm);
    rd_addr = a;
    #1;
    chk(nm, 32'(rd_pstate), 32'(exp));
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_test_rst_n", 32'(test_rst_n), 0);
    chk("rst_busy",       32'(busy), 0);
    chk("rst_done_err",   {30'd0, done, error}, 0);
    chk("rst_err_code",   32'(err_code), 0);
    chk("rst_retry_pmax", {29'd0, retry_cnt, pmax_warn}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // bad configuration
    push_ev(1'b0, 1'b1, 2'd1, 2'd0, 1'b0);
    do_start(4'd0);
    chk("cfg0_error", 32'(error), 1);
    chk("cfg0_err_code", 32'(err_code), 1);
    chk("cfg0_rst_busy", {30'd0, test_rst_n, busy}, 0);
    do_start(4'd9);
    chk("cfg9_err_code", 32'(err_code), 1);
    chk("cfg9_busy", 32'(busy), 0);

    // basic 3-layer run from FAIL
    do_start(4'd3);
    chk("launch_busy", 32'(busy), 1);
    chk("launch_err_clr", 32'(err_code), 0);
    cycles_until(1'b1, 64, n);
    chk("rst_pulse1", n, 4);
    send(4'd0, 4'd1);
    send(4'd1, 4'd2);
    chk("not_done_early", 32'(done), 0);
    push_ev(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    send(4'd2, 4'd3);
    chk("done_latency", 32'(done), 1);
    rd(4'd0, 4'd1, "rd0");
    rd(4'd1, 4'd2, "rd1");
    rd(4'd2, 4'd3, "rd2");
    rd(4'd3, 4'd0, "rd3_unwritten");
    rd(4'd9, 4'd0, "rd9_oob");

    // pmax, last-write-wins, ignored frames
    do_start(4'd2);
    cycles_until(1'b1, 64, n);
    chk("rst_pulse_pmax", n, 4);
    send(4'd1, 4'd3);
    send(4'd1, 4'hF);
    send(4'd0, 4'd7, 16'hBEEF);
    chk("bad_magic_no_done", 32'(done), 0);
    send(4'd3, 4'd8);
    chk("oob_src_no_done", 32'(done), 0);
    push_ev(1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    send(4'd0, 4'd5);
    rd(4'd1, 4'hF, "rd1_last_write");
    rd(4'd0, 4'd5, "rd0_after_bad_magic");
    rd(4'd3, 4'd0, "rd3_oob_ignored");
    chk("pmax_warn", 32'(pmax_warn), 1);
`ifdef STACK_CTRL_STATS_EN
    chk("frame_cnt", 32'(frame_cnt), 4);
`endif

    // timeout with retries
    do_start(4'd2);
    chk("pmax_cleared", 32'(pmax_warn), 0);
    cycles_until(1'b1, 64, n);
    chk("retry_pulse1", n, 4);
    send(4'd0, 4'd6);
    cycles_until(1'b0, 2000, n);
    chk("run_len1", n, 1024);
    chk("retry_cnt1", 32'(retry_cnt), 1);
    cycles_until(1'b1, 64, n);
    chk("retry_pulse2", n, 4);
    cycles_until(1'b0, 2000, n);
    chk("run_len2", n, 1024);
    chk("retry_cnt2", 32'(retry_cnt), 2);
    cycles_until(1'b1, 64, n);
    chk("retry_pulse3", n, 4);
    push_ev(1'b0, 1'b1, 2'd2, 2'd2, 1'b0);
    cycles_until(1'b0, 2000, n);
    chk("run_len3", n, 1024);
    chk("fail_busy", 32'(busy), 0);
    rd(4'd0, 4'd6, "table_kept");

    // frame on the expiry cycle
    do_start(4'd2);
    cycles_until(1'b1, 64, n);
    repeat (1023) tick();
    send(4'd0, 4'd2);
    chk("expiry_frame_run", {30'd0, test_rst_n, busy}, 3);
    chk("expiry_no_retry", 32'(retry_cnt), 0);
    push_ev(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    send(4'd1, 4'd4);

    // async reset mid-run, then clean relaunch
    do_start(4'd3);
    cycles_until(1'b1, 64, n);
    send(4'd0, 4'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", {26'd0, test_rst_n, busy, done, error, pmax_warn, |err_code}, 0);
    rd(4'd0, 4'd0, "midrst_table");
    tick();
    rst_n = 1'b1;
    tick();
    do_start(4'd1);
    cycles_until(1'b1, 64, n);
    chk("relaunch_pulse", n, 4);
    push_ev(1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    send(4'd0, 4'd9);
    rd(4'd0, 4'd9, "relaunch_rd0");

    tick(); tick();
    chk("events_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
